// File: rtl/fir_pkg.sv
// Shared constants, state encoding and width helper for the FIR shift-accumulate sequencer.
package fir_pkg;

   localparam int unsigned N_TAPS_DEF = 8;
   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned COEF_W_DEF = 16;

   localparam logic [2:0] ST_IDLE  = 3'b001;
   localparam logic [2:0] ST_ACCUM = 3'b010;
   localparam logic [2:0] ST_OUT   = 3'b100;

   typedef enum logic [2:0] {
      StIdle  = ST_IDLE,
      StAccum = ST_ACCUM,
      StOut   = ST_OUT
   } fir_state_e;

   // Wide enough that a full N_TAPS sum of full-scale products cannot overflow.
   function automatic int unsigned acc_width(input int unsigned data_w,
                                             input int unsigned coef_w,
                                             input int unsigned n_taps);
      return data_w + coef_w + $clog2(n_taps);
   endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Sample delay line: x[0] takes the new sample, x[k] takes x[k-1], all on one shift edge.
module fir_delay_line #(
   parameter int unsigned N_TAPS = 8,
   parameter int unsigned DATA_W = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       shift_i,
   input  logic [DATA_W-1:0]          data_i,
   output logic [N_TAPS*DATA_W-1:0]   x_o
);

   logic [DATA_W-1:0] x_q [N_TAPS];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < int'(N_TAPS); k++) begin
            x_q[k] <= '0;
         end
      end else if (shift_i) begin
         x_q[0] <= data_i;
         for (int k = 1; k < int'(N_TAPS); k++) begin
            x_q[k] <= x_q[k-1];
         end
      end
   end

   for (genvar g = 0; g < int'(N_TAPS); g++) begin : gen_flat
      assign x_o[g*DATA_W +: DATA_W] = x_q[g];
   end

endmodule

// File: rtl/fir_shift_accum_seq.sv
// One-output FIR sequencer: accept a sample, run N_TAPS MAC cycles, hold the result until taken.
// Optional macro FIR_OVERLAP_EN lets a new sample enter ACCUM straight from OUT.
module fir_shift_accum_seq
   import fir_pkg::*;
#(
   parameter  int unsigned N_TAPS = N_TAPS_DEF,
   parameter  int unsigned DATA_W = DATA_W_DEF,
   parameter  int unsigned COEF_W = COEF_W_DEF,
   localparam int unsigned ACC_W  = acc_width(DATA_W, COEF_W, N_TAPS),
   localparam int unsigned AW     = $clog2(N_TAPS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_vld,
   output logic                     in_rdy,
   input  logic        [DATA_W-1:0] in_data,
   output logic        [AW-1:0]     coef_addr,
   input  logic        [COEF_W-1:0] coef_data,
   output logic                     loop_last,
   output logic        [2:0]        fsm_output,
   output logic                     out_vld,
   input  logic                     out_rdy,
   output logic signed [ACC_W-1:0]  out_data
);

   fir_state_e               state_q, state_d;
   logic [AW-1:0]            tap_q, tap_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [ACC_W-1:0]  out_data_q, out_data_d;
   logic                     shift;
   logic                     accept;
   logic [N_TAPS*DATA_W-1:0] x_flat;
   logic [DATA_W-1:0]        x_sel;
   logic signed [ACC_W-1:0]  x_ext, c_ext, acc_sum;

   fir_delay_line #(
      .N_TAPS (N_TAPS),
      .DATA_W (DATA_W)
   ) u_delay_line (
      .clk_i   (clk),
      .rst_ni  (rst),
      .shift_i (shift),
      .data_i  (in_data),
      .x_o     (x_flat)
   );

`ifdef FIR_OVERLAP_EN
   assign in_rdy = rst & ((state_q == StIdle) | ((state_q == StOut) & out_rdy));
`else
   assign in_rdy = rst & (state_q == StIdle);
`endif

   assign accept     = in_vld & in_rdy;
   assign coef_addr  = tap_q;
   assign loop_last  = (state_q == StAccum) && (tap_q == AW'(N_TAPS - 1));
   assign fsm_output = state_q;
   assign out_vld    = (state_q == StOut);
   assign out_data   = out_data_q;

   // Both operands sign-extended to ACC_W so the product and sum are exact.
   assign x_sel   = x_flat[32'(tap_q) * DATA_W +: DATA_W];
   assign x_ext   = ACC_W'($signed(x_sel));
   assign c_ext   = ACC_W'($signed(coef_data));
   assign acc_sum = acc_q + x_ext * c_ext;

   always_comb begin
      state_d    = state_q;
      tap_d      = tap_q;
      acc_d      = acc_q;
      out_data_d = out_data_q;
      shift      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               shift   = 1'b1;
               acc_d   = '0;
               tap_d   = '0;
               state_d = StAccum;
            end
         end
         StAccum: begin
            acc_d = acc_sum;
            if (loop_last) begin
               out_data_d = acc_sum;
               tap_d      = '0;
               state_d    = StOut;
            end else begin
               tap_d = tap_q + AW'(1);
            end
         end
         StOut: begin
            if (out_rdy) begin
               state_d = StIdle;
`ifdef FIR_OVERLAP_EN
               if (in_vld) begin
                  shift   = 1'b1;
                  acc_d   = '0;
                  tap_d   = '0;
                  state_d = StAccum;
               end
`endif
            end
         end
         default: begin
            state_d = StIdle;
            tap_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         tap_q      <= '0;
         acc_q      <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         tap_q      <= tap_d;
         acc_q      <= acc_d;
         out_data_q <= out_data_d;
      end
   end

endmodule

// File: tb/tb_fir_shift_accum_seq.sv
// Self-checking bench for fir_shift_accum_seq (N_TAPS=4, coefficients 1,2,3,4).
module tb_fir_shift_accum_seq;

   localparam int NT    = 4;
   localparam int ACC_W = 34;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    in_vld;
   logic                    in_rdy;
   logic signed [15:0]      in_data;
   logic [1:0]              coef_addr;
   logic signed [15:0]      coef_data;
   logic                    loop_last;
   logic [2:0]              fsm_output;
   logic                    out_vld;
   logic                    out_rdy;
   logic signed [ACC_W-1:0] out_data;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int acc_cyc = 0;
   longint exp_q[$];

   typedef struct {
      logic signed [15:0]      din;
      logic signed [ACC_W-1:0] dout;
   } vec_t;
   vec_t tbl[15];

   fir_shift_accum_seq #(
      .N_TAPS (NT),
      .DATA_W (16),
      .COEF_W (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_vld     (in_vld),
      .in_rdy     (in_rdy),
      .in_data    (in_data),
      .coef_addr  (coef_addr),
      .coef_data  (coef_data),
      .loop_last  (loop_last),
      .fsm_output (fsm_output),
      .out_vld    (out_vld),
      .out_rdy    (out_rdy),
      .out_data   (out_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign coef_data = $signed({14'd0, coef_addr}) + 16'sd1;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Per-cycle monitor: scoreboard pop on output handshake, tap/loop_last/one-hot checks.
   always @(negedge clk) begin
      if (!rst) begin
         acc_cyc = 0;
      end else begin
         chk("fsm_onehot", longint'($onehot(fsm_output)), 1);
         if (fsm_output == 3'b010) begin
            chk("loop_last_accum", longint'(loop_last), longint'(acc_cyc == NT - 1));
            chk("coef_addr_accum", longint'(coef_addr), acc_cyc);
            acc_cyc++;
         end else begin
            chk("loop_last_idle", longint'(loop_last), 0);
            chk("coef_addr_idle", longint'(coef_addr), 0);
            acc_cyc = 0;
         end
         if (out_vld && out_rdy) begin
            if (exp_q.size() == 0) chk("unexpected_output", out_data, -1);
            else chk("out_data", out_data, exp_q.pop_front());
         end
      end
   end

   task automatic check_reset_vals();
      chk("rst_fsm", longint'(fsm_output), 1);
      chk("rst_out_vld", longint'(out_vld), 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_loop_last", longint'(loop_last), 0);
      chk("rst_in_rdy", longint'(in_rdy), 0);
      chk("rst_coef_addr", longint'(coef_addr), 0);
   endtask

   // Called #1 after a rising edge; leaves the same phase.
   task automatic do_reset();
      rst = 1'b0;
      in_vld = 1'b0;
      exp_q.delete();
      #1;
      check_reset_vals();
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic send(input logic signed [15:0] d, input longint exp, output int hs);
      int n = 0;
      in_vld = 1'b1;
      in_data = d;
      exp_q.push_back(exp);
      hs = -1;
      forever begin
         @(negedge clk);
         if (in_rdy) begin
            @(posedge clk);
            #1 hs = cyc;
            break;
         end
         @(posedge clk);
         #1 n++;
         if (n > 200) begin
            chk("send_timeout", 0, 1);
            break;
         end
      end
      in_vld = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0) begin
         @(posedge clk);
         #1 n++;
         if (n > 200) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs, hs_prev, n;
      longint hist[NT];
      longint y;

      tbl[0]  = '{16'sd1, 34'sd1};
      tbl[1]  = '{16'sd0, 34'sd2};
      tbl[2]  = '{16'sd0, 34'sd3};
      tbl[3]  = '{16'sd0, 34'sd4};
      tbl[4]  = '{16'sd0, 34'sd0};
      for (int i = 5; i < 10; i++) tbl[i].din = -16'sd32768;
      tbl[5].dout = -34'sd32768;   tbl[6].dout = -34'sd98304;
      tbl[7].dout = -34'sd196608;  tbl[8].dout = -34'sd327680;
      tbl[9].dout = -34'sd327680;
      for (int i = 10; i < 15; i++) tbl[i].din = 16'sd32767;
      tbl[10].dout = 34'sd32767;   tbl[11].dout = 34'sd98301;
      tbl[12].dout = 34'sd196602;  tbl[13].dout = 34'sd327670;
      tbl[14].dout = 34'sd327670;

      rst = 1'b0; in_vld = 1'b0; in_data = '0; out_rdy = 1'b1;
      repeat (3) @(posedge clk);
      #1 check_reset_vals();
      rst = 1'b1;
      #1 chk("idle_in_rdy", longint'(in_rdy), 1);

      // Impulse and full-scale groups, each from cleared history.
      for (int i = 0; i < 15; i++) begin
         if (i % 5 == 0 && i > 0) begin
            drain();
            do_reset();
         end
         send(tbl[i].din, tbl[i].dout, hs);
      end
      drain();

      // Latency: out_vld first seen after edge E+4; in_vld during ACCUM is ignored.
      do_reset();
      in_vld = 1'b1; in_data = 16'sd9; exp_q.push_back(9);
      n = 0;
      forever begin
         @(negedge clk);
         if (in_rdy || n > 50) break;
         n++;
      end
      chk("lat_accept", longint'(in_rdy), 1);
      @(posedge clk);
      #1 in_data = 16'sd77;
      for (int c = 0; c <= NT; c++) begin
         @(negedge clk);
         chk("lat_out_vld", longint'(out_vld), longint'(c == NT));
         if (c < NT) chk("accum_in_rdy", longint'(in_rdy), 0);
         if (c == NT - 1) in_vld = 1'b0;
      end
      @(posedge clk);
      #1 drain();

      // Backpressure: OUT holds six cycles, then returns to IDLE.
      do_reset();
      out_rdy = 1'b0;
      send(16'sd5, 5, hs);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_vld && n < 50);
      chk("bp_out_vld", longint'(out_vld), 1);
      for (int c = 0; c < 6; c++) begin
         chk("bp_out_data", out_data, 5);
         chk("bp_in_rdy", longint'(in_rdy), 0);
         chk("bp_fsm", longint'(fsm_output), 4);
         @(negedge clk);
      end
      @(posedge clk);
      #1 out_rdy = 1'b1;
      @(posedge clk);
      #1 chk("bp_release_idle", longint'(fsm_output), 1);
      drain();

      // Reset at tap 2 after nonzero history: next output must use zero history.
      do_reset();
      send(16'sd7, 7, hs);
      drain();
      send(16'sd8, 0, hs);
      repeat (2) @(posedge clk);
      #1 chk("mid_tap2", longint'(coef_addr), 2);
      do_reset();
      send(16'sd5, 5, hs);
      drain();

      // Back-to-back throughput.
      do_reset();
      hs_prev = -1;
      for (int i = 1; i <= 4; i++) begin
         y = (i == 1) ? 1 : (i == 2) ? 4 : (i == 3) ? 10 : 20;
         send(16'(i), y, hs);
`ifdef FIR_OVERLAP_EN
         if (hs_prev >= 0) chk("overlap_interval", hs - hs_prev, NT + 1);
`else
         if (hs_prev >= 0) chk("seq_interval", hs - hs_prev, NT + 2);
`endif
         hs_prev = hs;
      end
      drain();

      // Random samples against a reference convolution.
      do_reset();
      for (int k = 0; k < NT; k++) hist[k] = 0;
      for (int i = 0; i < 8; i++) begin
         logic signed [15:0] d;
         d = 16'($urandom);
         for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = longint'(d);
         y = 0;
         for (int k = 0; k < NT; k++) y += hist[k] * (k + 1);
         send(d, y, hs);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
